// File: rtl/ps2_mouse_sequencer_if.sv
// Handshake and byte-stream bundle between the mouse sequencer (master)
// and the PS/2 transceiver (slave).
interface ps2_mouse_sequencer_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output the_command, send_command,
    input  command_was_sent, error_communication_timed_out,
    input  received_data, received_data_en
  );

  modport slave (
    input  the_command, send_command,
    output command_was_sent, error_communication_timed_out,
    output received_data, received_data_en
  );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up (reset, self-test, enable reporting) with timeouts and
// retries, followed by 3-byte stream packet assembly into registered outputs.
module ps2_mouse_sequencer #(
  parameter int TIMEOUT_W   = 25,
  parameter int MAX_RETRIES = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  ps2_mouse_sequencer_if.master ps2,
  output logic                 init_done,
  output logic                 init_error,
  output logic [8:0]           mouse_dx,
  output logic [8:0]           mouse_dy,
  output logic [2:0]           mouse_buttons,
  output logic [1:0]           mouse_overflow,
  output logic                 packet_valid
);

  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RST_SEND, RST_ACK, RST_BAT, RST_ID, EN_SEND, EN_ACK, STREAM, FAIL
  } state_e;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [1:0]           idx_q, idx_d;
  logic [6:0]           hdr_q, hdr_d;   // {Yovf, Xovf, Ysign, Xsign, M, R, L}
  logic [7:0]           xb_q, xb_d;
  logic [7:0]           cmd_q, cmd_d;
  logic                 send_q, send_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [8:0]           dx_q, dx_d, dy_q, dy_d;
  logic [2:0]           btn_q, btn_d;
  logic [1:0]           ovf_q, ovf_d;
  logic                 pv_q, pv_d;

  logic       timeout, go_err;
  logic [7:0] exp_byte, rx;
  state_e     exp_next;

  assign timeout = &cnt_q;
  assign rx      = ps2.received_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + TIMEOUT_W'(1);
    retry_d  = retry_q;
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    xb_d     = xb_q;
    cmd_d    = cmd_q;
    send_d   = 1'b0;
    err_d    = err_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    btn_d    = btn_q;
    ovf_d    = ovf_q;
    pv_d     = 1'b0;
    go_err   = 1'b0;
    exp_byte = 8'hFA;
    exp_next = RST_BAT;

    case (state_q)
      RST_SEND, EN_SEND: begin
        cnt_d = '0;
        // Acks only count while the request is actually on the wire.
        if (send_q && ps2.command_was_sent)
          state_d = (state_q == RST_SEND) ? RST_ACK : EN_ACK;
        else if (send_q && ps2.error_communication_timed_out)
          go_err = 1'b1;
        else
          send_d = 1'b1;
      end
      RST_ACK, RST_BAT, RST_ID, EN_ACK: begin
        case (state_q)
          RST_BAT: begin exp_byte = 8'hAA; exp_next = RST_ID;  end
          RST_ID:  begin exp_byte = 8'h00; exp_next = EN_SEND; end
          EN_ACK:  begin exp_byte = 8'hFA; exp_next = STREAM;  end
          default: begin exp_byte = 8'hFA; exp_next = RST_BAT; end
        endcase
        if (ps2.received_data_en) begin
          if (rx == exp_byte) begin
            state_d = exp_next;
          end else if (rx == 8'hFE) begin
            state_d = (state_q == EN_ACK) ? EN_SEND : RST_SEND;
            if (retry_q != '1) retry_d = retry_q + RW'(1);
          end else begin
            go_err = 1'b1;
          end
        end else if (timeout) begin
          go_err = 1'b1;
        end
      end
      STREAM: begin
        if (ps2.received_data_en) begin
          cnt_d = '0;
          case (idx_q)
            2'd0: if (rx[3]) begin
              hdr_d = {rx[7:4], rx[2:0]};
              idx_d = 2'd1;
            end
            2'd1: begin
              xb_d  = rx;
              idx_d = 2'd2;
            end
            default: begin
              dx_d  = {hdr_q[3], xb_q};
              dy_d  = {hdr_q[4], rx};
              btn_d = hdr_q[2:0];
              ovf_d = hdr_q[6:5];
              pv_d  = 1'b1;
              idx_d = 2'd0;
            end
          endcase
        end else if (idx_q == 2'd0 || timeout) begin
          cnt_d = '0;
          idx_d = 2'd0;
        end
      end
      default: cnt_d = '0;
    endcase

    if (go_err) begin
      if (retry_q >= MAX_R) begin
        state_d = FAIL;
        err_d   = 1'b1;
      end else begin
        retry_d = retry_q + RW'(1);
        state_d = RST_SEND;
      end
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == STREAM && state_q != STREAM) begin
      retry_d = '0;
      idx_d   = 2'd0;
    end
    if (state_d == RST_SEND)     cmd_d = 8'hFF;
    else if (state_d == EN_SEND) cmd_d = 8'hF4;
    done_d = (state_d == STREAM);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= RST_SEND;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= 2'd0;
      hdr_q   <= '0;
      xb_q    <= '0;
      cmd_q   <= 8'hFF;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      btn_q   <= '0;
      ovf_q   <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      xb_q    <= xb_d;
      cmd_q   <= cmd_d;
      send_q  <= send_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      btn_q   <= btn_d;
      ovf_q   <= ovf_d;
      pv_q    <= pv_d;
    end
  end

  assign ps2.the_command  = cmd_q;
  assign ps2.send_command = send_q;
  assign init_done        = done_q;
  assign init_error       = err_q;
  assign mouse_dx         = dx_q;
  assign mouse_dy         = dy_q;
  assign mouse_buttons    = btn_q;
  assign mouse_overflow   = ovf_q;
  assign packet_valid     = pv_q;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Directed bench: a transceiver/mouse model drives the bus, expected packets
// go into a queue that a negedge monitor drains whenever packet_valid fires.
module tb_ps2_mouse_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       init_done, init_error, packet_valid;
  logic [8:0] mouse_dx, mouse_dy;
  logic [2:0] mouse_buttons;
  logic [1:0] mouse_overflow;

  always #10 clk = ~clk;

  ps2_mouse_sequencer_if bus ();

  ps2_mouse_sequencer #(.TIMEOUT_W(8), .MAX_RETRIES(3)) dut (
    .CLOCK_50       (clk),
    .resetn         (resetn),
    .ps2            (bus),
    .init_done      (init_done),
    .init_error     (init_error),
    .mouse_dx       (mouse_dx),
    .mouse_dy       (mouse_dy),
    .mouse_buttons  (mouse_buttons),
    .mouse_overflow (mouse_overflow),
    .packet_valid   (packet_valid)
  );

  typedef struct packed {
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;
    logic [1:0] ovf;
  } pkt_t;

  pkt_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pkt_seen = 0;
  int   sends = 0;
  int   ff_sends = 0;
  logic prev_send = 1'b0;
  logic prev_pv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts request rising edges and scores every packet strobe.
  always @(negedge clk) begin
    pkt_t got;
    pkt_t e;
    if (bus.send_command && !prev_send) begin
      sends++;
      if (bus.the_command == 8'hFF) ff_sends++;
    end
    if (packet_valid) begin
      pkt_seen++;
      got = {mouse_dx, mouse_dy, mouse_buttons, mouse_overflow};
      $display("[TB] packet dx=0x%0h dy=0x%0h btn=%b ovf=%b", mouse_dx, mouse_dy, mouse_buttons, mouse_overflow);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_packet: got 0x%0h, expected no packet", got);
      end else begin
        e = exp_q.pop_front();
        check("packet", 32'(got), 32'(e));
      end
      check("pv_one_cycle", 32'(prev_pv), 32'd0);
    end
    prev_pv   = packet_valid;
    prev_send = bus.send_command;
  end

  task automatic xcvr_ack(input logic [7:0] cmd);
    int n = 0;
    @(negedge clk);
    while (bus.send_command !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL send_wait: send_command=0, expected 1 within 2000 cycles");
    end else begin
      $display("[TB] command 0x%0h requested", bus.the_command);
      check("the_command", 32'(bus.the_command), 32'(cmd));
      repeat (20) @(posedge clk);
      #1 bus.command_was_sent = 1'b1;
      @(posedge clk);
      #1 bus.command_was_sent = 1'b0;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk);
    #1 bus.received_data = b;
    bus.received_data_en = 1'b1;
    @(posedge clk);
    #1 bus.received_data_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn, input logic [1:0] ovf);
    pkt_t p;
    p = {dx, dy, btn, ovf};
    exp_q.push_back(p);
  endtask

  task automatic full_init();
    xcvr_ack(8'hFF);
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    rx_byte(8'h00);
    xcvr_ack(8'hF4);
    rx_byte(8'hFA);
  endtask

  task automatic settle_and_check(input string name, input int p0, input int exp_pkts);
    repeat (5) @(posedge clk);
    #1;
    check({name, "_pkt_count"}, 32'(pkt_seen - p0), 32'(exp_pkts));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  int s0, f0, p0;

  initial begin
    bus.command_was_sent              = 1'b0;
    bus.error_communication_timed_out = 1'b0;
    bus.received_data                 = 8'h00;
    bus.received_data_en              = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_send_command", 32'(bus.send_command), 32'd0);
    check("rst_the_command", 32'(bus.the_command), 32'hFF);
    check("rst_flags", {29'd0, init_done, init_error, packet_valid}, 32'd0);
    check("rst_mouse", {9'd0, mouse_dx, mouse_dy, mouse_buttons, mouse_overflow}, 32'd0);
    s0 = sends;
    resetn = 1'b1;

    // Clean init
    full_init();
    @(negedge clk);
    check("init_done", 32'(init_done), 32'd1);
    check("init_error", 32'(init_error), 32'd0);
    check("separate_requests", 32'(sends - s0), 32'd2);

    // Stream packet
    p0 = pkt_seen;
    rx_byte(8'h19);
    rx_byte(8'hF0);
    push(9'h1F0, 9'h005, 3'b001, 2'b00);
    rx_byte(8'h05);
    settle_and_check("packet1", p0, 1);

    // Resync
    p0 = pkt_seen;
    rx_byte(8'h02);
    rx_byte(8'h08);
    rx_byte(8'h01);
    push(9'h001, 9'h002, 3'b000, 2'b00);
    rx_byte(8'h02);
    settle_and_check("resync", p0, 1);

    // Gap timeout
    p0 = pkt_seen;
    rx_byte(8'h08);
    rx_byte(8'h10);
    repeat (300) @(posedge clk);
    rx_byte(8'h08);
    rx_byte(8'h03);
    push(9'h003, 9'h004, 3'b000, 2'b00);
    rx_byte(8'h04);
    settle_and_check("gap", p0, 1);
    check("hold_dx", 32'(mouse_dx), 32'h003);

    // Mid-packet reset
    p0 = pkt_seen;
    rx_byte(8'h08);
    rx_byte(8'h01);
    resetn = 1'b0;
    #2;
    check("midrst_mouse", {9'd0, mouse_dx, mouse_dy, mouse_buttons, mouse_overflow}, 32'd0);
    check("midrst_flags", {28'd0, init_done, init_error, packet_valid, bus.send_command}, 32'd0);
    check("midrst_the_command", 32'(bus.the_command), 32'hFF);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    f0 = ff_sends;

    // Retry after 0xFE, continuing from the reset above
    xcvr_ack(8'hFF);
    rx_byte(8'hFE);
    full_init();
    @(negedge clk);
    check("retry_init_done", 32'(init_done), 32'd1);
    check("retry_ff_sends", 32'(ff_sends - f0), 32'd2);
    rx_byte(8'h0A);
    rx_byte(8'h07);
    push(9'h007, 9'h009, 3'b010, 2'b00);
    rx_byte(8'h09);
    settle_and_check("after_reset", p0, 1);

    // Mouse never answers
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    f0 = ff_sends;
    s0 = sends;
    repeat (4) xcvr_ack(8'hFF);
    repeat (600) @(posedge clk);
    #1;
    check("fail_init_error", 32'(init_error), 32'd1);
    check("fail_ff_sends", 32'(ff_sends - f0), 32'd4);
    check("fail_all_sends", 32'(sends - s0), 32'd4);
    check("fail_send_low", {30'd0, bus.send_command, init_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_sequencer.md
# ps2_mouse_sequencer

- Sits between the game logic and the PS/2 transceiver (`the_command`/`send_command` handshake, `received_data`/`received_data_en` byte stream).
- Brings an attached PS/2 mouse out of reset and into stream mode: reset, self-test check, enable reporting, with response timeouts and bounded retries.
- Once the mouse is streaming, assembles 3-byte movement packets into registered dx/dy/button outputs with a one-cycle valid strobe.

## Interface
Parameters:
- `TIMEOUT_W`, 25 — width of the response/gap counter; a timeout fires when the counter reaches all-ones (2^25−1 cycles ≈ 0.67 s at 50 MHz).
- `MAX_RETRIES`, 3 — number of full init restarts allowed before `init_error` is raised.

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `the_command`  out  8  command byte to the transceiver.
- `send_command`  out  1  command request; held high until the transceiver acknowledges.
- `command_was_sent`  in  1  transceiver: command transmitted.
- `error_communication_timed_out`  in  1  transceiver: command transmit failed.
- `received_data`  in  8  byte from the mouse.
- `received_data_en`  in  1  one-cycle strobe; `received_data` is valid this cycle.
- `init_done`  out  1  high while in the stream state.
- `init_error`  out  1  sticky; retries exhausted.
- `mouse_dx`  out  9  signed X delta {Xsign, byte1}.
- `mouse_dy`  out  9  signed Y delta {Ysign, byte2}.
- `mouse_buttons`  out  3  {middle, right, left}.
- `mouse_overflow`  out  2  {Yovf, Xovf}.
- `packet_valid`  out  1  one-cycle strobe; new packet on the `mouse_*` outputs.

## Operation
State machine:
- RST_SEND: drive `the_command`=0xFF, `send_command`=1.
- RST_ACK: expect 0xFA.
- RST_BAT: expect 0xAA.
- RST_ID: expect 0x00.
- EN_SEND: drive `the_command`=0xF4, `send_command`=1.
- EN_ACK: expect 0xFA.
- STREAM: packet assembly.
- FAIL: terminal until reset.

Send states (RST_SEND, EN_SEND):
- Hold `send_command`=1 until `command_was_sent` or `error_communication_timed_out`.
- On `command_was_sent`: go to the matching wait state (RST_ACK or EN_ACK).
- On `error_communication_timed_out`: take the error path.
- `send_command` drops in the same edge as the state change. It stays 0 for at least one cycle before any re-send.

Wait states (RST_ACK, RST_BAT, RST_ID, EN_ACK):
- The counter clears on entry and increments each cycle.
- On `received_data_en`:
  - expected byte → next state;
  - 0xFE (resend) → return to the send state of the current command and increment the retry count;
  - any other byte → error path.
- Counter reaches all-ones with no byte → error path.

Error path:
- Increment `retry_cnt`, go to RST_SEND.
- If `retry_cnt` already equals `MAX_RETRIES`: go to FAIL and set `init_error`=1.
- `retry_cnt` clears on entry to STREAM.

STREAM:
- A 2-bit byte index `idx` starts at 0.
- idx 0: accept the byte only if bit3=1; otherwise discard it and stay at idx 0 (resync).
- idx 0 field layout: bit0 L, bit1 R, bit2 M, bit4 Xsign, bit5 Ysign, bit6 Xovf, bit7 Yovf.
- idx 1: capture X byte. idx 2: capture Y byte.
- The third byte updates all `mouse_*` outputs and pulses `packet_valid`, then `idx` returns to 0.
- Inter-byte gap: the counter clears on each byte and runs while `idx`≠0. On timeout, `idx` returns to 0 and the partial packet is discarded without updating outputs.
- `send_command` stays 0 in STREAM and FAIL.

## Timing
- Reset values: state RST_SEND; `send_command`=0 during reset, 1 from the first edge after `resetn` deasserts.
  - `the_command`=0xFF.
  - `init_done`=0, `init_error`=0.
  - `mouse_dx`=0, `mouse_dy`=0, `mouse_buttons`=0, `mouse_overflow`=0.
  - `packet_valid`=0, `idx`=0, `retry_cnt`=0.
- All outputs are registered.
- State change happens on the edge that samples `received_data_en`, `command_was_sent` or a timeout.
- `packet_valid` is high exactly one cycle, on the cycle after the third-byte strobe. Data outputs change on that same edge and hold until the next packet.
- `init_done` goes high on the cycle after the 0xFA for 0xF4 is accepted.
- `command_was_sent` and `error_communication_timed_out` in the same cycle: `command_was_sent` wins.
- `received_data_en` in a send state is ignored.
- A byte strobe in the same cycle as a timeout: the byte wins.
- Timeout is measured from state entry: it fires exactly 2^`TIMEOUT_W`−1 cycles after entry with no strobe.
- `resetn` low mid-packet or mid-handshake: immediate return to the reset values; the partial packet is lost.

## Test plan
- Clean init (`TIMEOUT_W`=8), model acks each command 20 cycles after the request:
  - 0xFF sent → bytes FA, AA, 00;
  - 0xF4 sent → byte FA;
  - required: `init_done`=1, `init_error`=0, `send_command` low for at least one cycle between the two commands.
- Stream packet, bytes 0x19, 0xF0, 0x05:
  - required: one `packet_valid` pulse;
  - `mouse_dx`=−16 (0x1F0), `mouse_dy`=+5, `mouse_buttons`=3'b001, `mouse_overflow`=0.
- Resync: bytes 0x02 (bit3=0, discarded), then 0x08, 0x01, 0x02:
  - required: exactly one packet, dx=1, dy=2.
- Gap timeout: bytes 0x08, 0x10, idle 300 cycles, then 0x08, 0x03, 0x04:
  - required: one packet only, dx=3, dy=4.
- Retry: model answers 0xFE to 0xFF once, then a normal sequence:
  - required: 0xFF re-sent and init completes.
- FAIL: never respond (`MAX_RETRIES`=3):
  - required: exactly 4 sends of 0xFF, then `init_error`=1 and `send_command` stays 0.
- Mid-operation reset: assert `resetn` between packet bytes:
  - required: all outputs return to reset values and init restarts with 0xFF.
